// File: rtl/m_store_buffer.sv
// MEM-stage store unit: encodes sb/sh/sw into word address + byte enables and queues them for data memory.
// Latency 1 cycle enqueue-to-head; st_ready drops when full; head holds while mem_ready is low.
module m_store_buffer #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     st_valid,
  input  logic [1:0]               st_op,
  input  logic [31:0]              st_addr,
  input  logic [31:0]              st_wdata,
  output logic                     st_ready,
  output logic                     st_err,
  input  logic [31:0]              ld_addr,
  output logic                     ld_conflict,
  output logic [31:0]              m_data_addr,
  output logic [31:0]              m_data_wdata,
  output logic [3:0]               m_data_byteen,
  output logic                     mem_valid,
  input  logic                     mem_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef struct packed {
    logic [29:0] waddr;
    logic [31:0] wdata;
    logic [3:0]  byteen;
  } entry_t;

  entry_t          mem_q [DEPTH];
  entry_t          mem_d [DEPTH];
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            st_err_q, st_err_d;

  entry_t          new_e;
  logic            legal;
  logic [1:0]      a;
  logic            present, accept, drain;
  logic            unused_ld_bits;

  assign unused_ld_bits = ^ld_addr[1:0];

  always_comb begin
    legal        = 1'b1;
    a            = st_addr[1:0];
    new_e        = '0;
    new_e.waddr  = st_addr[31:2];
    case (st_op)
      2'd1: begin
        new_e.byteen = 4'b0001 << a;
        new_e.wdata  = {4{st_wdata[7:0]}};
      end
      2'd2: begin
        legal        = ~a[0];
        new_e.byteen = a[1] ? 4'b1100 : 4'b0011;
        new_e.wdata  = {2{st_wdata[15:0]}};
      end
      2'd3: begin
        legal        = (a == 2'b00);
        new_e.byteen = 4'b1111;
        new_e.wdata  = st_wdata;
      end
      default: legal = 1'b0;
    endcase
  end

  assign st_ready  = (count_q != FULL_CNT);
  assign mem_valid = (count_q != '0);
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign st_err    = st_err_q;

  assign present = st_valid && st_ready;
  assign accept  = present && legal;
  assign drain   = mem_valid && mem_ready;

  assign m_data_addr   = {mem_q[rd_ptr_q].waddr, 2'b00};
  assign m_data_wdata  = mem_q[rd_ptr_q].wdata;
  assign m_data_byteen = mem_q[rd_ptr_q].byteen;

  // Occupancy bits let the conflict check ignore stale slots regardless of pointer position.
  always_comb begin
    ld_conflict = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_q[i] && (mem_q[i].waddr == ld_addr[31:2])) ld_conflict = 1'b1;
    end
  end

  always_comb begin
    mem_d    = mem_q;
    vld_d    = vld_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    st_err_d = present && !legal;
    if (drain) begin
      vld_d[rd_ptr_q] = 1'b0;
      rd_ptr_d        = rd_ptr_q + AW'(1);
    end
    if (accept) begin
      mem_d[wr_ptr_q] = new_e;
      vld_d[wr_ptr_q] = 1'b1;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    case ({accept, drain})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      vld_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      st_err_q <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
      vld_q    <= vld_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      st_err_q <= st_err_d;
    end
  end

endmodule

// File: tb/tb_m_store_buffer.sv
// Bench for m_store_buffer: scoreboard of encoded stores checked at the head each cycle, plus directed checks.
module tb_m_store_buffer;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        st_valid = 1'b0;
  logic [1:0]  st_op = 2'd0;
  logic [31:0] st_addr = '0;
  logic [31:0] st_wdata = '0;
  logic        st_ready;
  logic        st_err;
  logic [31:0] ld_addr = '0;
  logic        ld_conflict;
  logic [31:0] m_data_addr;
  logic [31:0] m_data_wdata;
  logic [3:0]  m_data_byteen;
  logic        mem_valid;
  logic        mem_ready = 1'b0;
  logic [2:0]  count;
  logic        empty;

  m_store_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .st_valid(st_valid), .st_op(st_op), .st_addr(st_addr), .st_wdata(st_wdata),
    .st_ready(st_ready), .st_err(st_err),
    .ld_addr(ld_addr), .ld_conflict(ld_conflict),
    .m_data_addr(m_data_addr), .m_data_wdata(m_data_wdata), .m_data_byteen(m_data_byteen),
    .mem_valid(mem_valid), .mem_ready(mem_ready),
    .count(count), .empty(empty)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;
  logic err_exp = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic encode(input logic [1:0] op, input logic [31:0] ad,
                                  input logic [31:0] d, output exp_t e);
    logic [1:0] a;
    logic       ok;
    a       = ad[1:0];
    e.addr  = ad & 32'hFFFF_FFFC;
    e.wdata = d;
    e.be    = 4'hF;
    ok      = 1'b0;
    case (op)
      2'd1: begin
        ok      = 1'b1;
        e.wdata = {d[7:0], d[7:0], d[7:0], d[7:0]};
        case (a)
          2'd0:    e.be = 4'b0001;
          2'd1:    e.be = 4'b0010;
          2'd2:    e.be = 4'b0100;
          default: e.be = 4'b1000;
        endcase
      end
      2'd2: begin
        ok      = (a[0] == 1'b0);
        e.wdata = {d[15:0], d[15:0]};
        e.be    = (a == 2'd2) ? 4'b1100 : 4'b0011;
      end
      2'd3: ok = (a == 2'd0);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Cycle model: checks DUT state against the scoreboard, then applies this cycle's accept/drain.
  exp_t mon_e;
  logic mon_ok, mon_hit, mon_acc, mon_drn;
  always @(negedge clk) begin
    if (reset) begin
      check_eq("count", 64'(count), 64'(sb_q.size()));
      check_eq("empty", 64'(empty), 64'(sb_q.size() == 0));
      check_eq("st_ready", 64'(st_ready), 64'(sb_q.size() != DEPTH));
      check_eq("mem_valid", 64'(mem_valid), 64'(sb_q.size() != 0));
      check_eq("st_err", 64'(st_err), 64'(err_exp));
      mon_hit = 1'b0;
      foreach (sb_q[i]) if (sb_q[i].addr[31:2] == ld_addr[31:2]) mon_hit = 1'b1;
      check_eq("ld_conflict", 64'(ld_conflict), 64'(mon_hit));
      if (sb_q.size() > 0) begin
        check_eq("head_addr", 64'(m_data_addr), 64'(sb_q[0].addr));
        check_eq("head_wdata", 64'(m_data_wdata), 64'(sb_q[0].wdata));
        check_eq("head_byteen", 64'(m_data_byteen), 64'(sb_q[0].be));
      end
      mon_ok  = encode(st_op, st_addr, st_wdata, mon_e);
      mon_acc = st_valid && (sb_q.size() != DEPTH) && mon_ok;
      mon_drn = (sb_q.size() != 0) && mem_ready;
      err_exp = st_valid && (sb_q.size() != DEPTH) && !mon_ok;
      if (mon_drn) void'(sb_q.pop_front());
      if (mon_acc) sb_q.push_back(mon_e);
    end
  end

  task automatic send(input logic [1:0] op, input logic [31:0] ad, input logic [31:0] d);
    int n;
    @(posedge clk); #1;
    st_valid = 1'b1; st_op = op; st_addr = ad; st_wdata = d;
    n = 0;
    @(negedge clk);
    while (!st_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!st_ready) check_eq("send_timeout", 64'(st_ready), 64'd1);
  endtask

  task automatic idle(input int n);
    @(posedge clk); #1;
    st_valid = 1'b0; st_op = 2'd0;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1);
  end

  initial begin
    #3;
    check_eq("rst_count", 64'(count), 64'd0);
    check_eq("rst_empty", 64'(empty), 64'd1);
    check_eq("rst_ready", 64'(st_ready), 64'd1);
    check_eq("rst_mvalid", 64'(mem_valid), 64'd0);
    check_eq("rst_err", 64'(st_err), 64'd0);
    check_eq("rst_conflict", 64'(ld_conflict), 64'd0);
    check_eq("rst_maddr", 64'(m_data_addr), 64'd0);
    check_eq("rst_mwdata", 64'(m_data_wdata), 64'd0);
    check_eq("rst_mbe", 64'(m_data_byteen), 64'd0);
    #21 reset = 1'b1;

    // First store after reset: 1-cycle latency to head.
    send(2'd1, 32'h0000_3002, 32'h1234_56AB);
    idle(1);
    check_eq("sb_addr", 64'(m_data_addr), 64'h3000);
    check_eq("sb_wdata", 64'(m_data_wdata), 64'hABAB_ABAB);
    check_eq("sb_byteen", 64'(m_data_byteen), 64'b0100);
    check_eq("sb_mvalid", 64'(mem_valid), 64'd1);
    check_eq("sb_count", 64'(count), 64'd1);
    mem_ready = 1'b1;
    idle(2);

    // In-order sh/sw then misaligned sh, and back-to-back illegal requests.
    send(2'd2, 32'h10, 32'hCAFE_BEEF);
    send(2'd3, 32'h14, 32'hDEAD_BEEF);
    send(2'd2, 32'h11, 32'h0000_7777);
    idle(3);
    check_eq("after_err_count", 64'(count), 64'd0);
    send(2'd0, 32'h20, 32'h1);
    send(2'd3, 32'h22, 32'h2);
    send(2'd1, 32'h23, 32'h0000_00C3);
    idle(3);

    // Fill with memory stalled, fifth store held by producer, then drain with wrap.
    @(posedge clk); #1 mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(2'd3, 32'(i * 4), 32'h100 + 32'(i));
    @(posedge clk); #1;
    st_valid = 1'b1; st_op = 2'd3; st_addr = 32'h10; st_wdata = 32'h104;
    repeat (3) begin
      @(negedge clk);
      check_eq("full_ready", 64'(st_ready), 64'd0);
      check_eq("full_head", 64'(m_data_addr), 64'h0);
    end
    @(posedge clk); #1 mem_ready = 1'b1;
    @(negedge clk);
    check_eq("full_before", 64'(count), 64'd4);
    @(negedge clk);
    check_eq("full_drain", 64'(count), 64'd3);
    idle(8);
    check_eq("drained_empty", 64'(empty), 64'd1);

    // Load-word conflict against a pending sb.
    @(posedge clk); #1 mem_ready = 1'b0;
    send(2'd1, 32'h203, 32'h55);
    @(posedge clk); #1;
    st_valid = 1'b0; st_op = 2'd0; ld_addr = 32'h200;
    @(negedge clk);
    check_eq("conflict_hit", 64'(ld_conflict), 64'd1);
    @(posedge clk); #1 ld_addr = 32'h204;
    @(negedge clk);
    check_eq("conflict_miss", 64'(ld_conflict), 64'd0);
    @(posedge clk); #1 ld_addr = 32'h200; mem_ready = 1'b1;
    @(negedge clk);
    check_eq("conflict_draining", 64'(ld_conflict), 64'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("conflict_gone", 64'(ld_conflict), 64'd0);

    // Asynchronous reset with entries pending.
    @(posedge clk); #1 mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(2'd3, 32'h40 + 32'(i * 4), 32'hA0 + 32'(i));
    @(posedge clk); #1;
    st_valid = 1'b0; st_op = 2'd0; ld_addr = 32'h44;
    @(negedge clk);
    check_eq("pre_rst_count", 64'(count), 64'd3);
    #2 reset = 1'b0;
    #1;
    check_eq("arst_mvalid", 64'(mem_valid), 64'd0);
    check_eq("arst_count", 64'(count), 64'd0);
    check_eq("arst_ready", 64'(st_ready), 64'd1);
    check_eq("arst_conflict", 64'(ld_conflict), 64'd0);
    check_eq("arst_maddr", 64'(m_data_addr), 64'd0);
    check_eq("arst_mwdata", 64'(m_data_wdata), 64'd0);
    check_eq("arst_mbe", 64'(m_data_byteen), 64'd0);
    sb_q.delete();
    err_exp = 1'b0;
    #1 reset = 1'b1;
    send(2'd3, 32'h80, 32'hCAFE_F00D);
    idle(1);
    check_eq("post_rst_head", 64'(m_data_addr), 64'h80);
    check_eq("post_rst_count", 64'(count), 64'd1);

    // Streaming: one store per cycle with memory always ready keeps count at 1.
    @(posedge clk); #1 mem_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      send(2'd3, 32'h100 + 32'(k * 4), 32'(k) + 32'h900);
      if (k >= 1) check_eq("stream_count", 64'(count), 64'd1);
    end
    idle(4);
    check_eq("final_empty", 64'(empty), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/m_store_buffer.md
# m_store_buffer

Memory-stage store unit for the pipelined CPU: the write-side counterpart of the load data-extension logic. It accepts `sb`, `sh` and `sw` requests from the MEM stage and rejects misaligned ones. Each accepted request becomes a word-aligned address, replicated write data and a byte-enable mask. Requests queue in a small FIFO and drain to the data-memory port over a valid/ready handshake, and the block flags pending stores that overlap a load's word.

## Interface
- `DEPTH`, 4: FIFO entries; a power of two, at least 2.
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: asynchronous reset, active-low (0 = reset).
- `st_valid` input 1: a store request is presented this cycle.
- `st_op` input 2: 2'd1 = sb, 2'd2 = sh, 2'd3 = sw; 2'd0 is illegal.
- `st_addr` input 32: byte address.
- `st_wdata` input 32: rt value; only the low byte or half is used for sb/sh.
- `st_ready` output 1: the FIFO can accept a request.
- `st_err` output 1: one-cycle pulse reporting a rejected request.
- `ld_addr` input 32: byte address of the load currently in MEM.
- `ld_conflict` output 1: a pending entry shares `ld_addr`'s word address.
- `m_data_addr` output 32: word-aligned address of the head entry.
- `m_data_wdata` output 32: data of the head entry.
- `m_data_byteen` output 4: byte enables of the head entry.
- `mem_valid` output 1: the head entry is valid.
- `mem_ready` input 1: the memory accepts the head entry this cycle.
- `count` output $clog2(DEPTH)+1: number of occupied entries.
- `empty` output 1: `count == 0`.

## Operation
- A request is **accepted** when `st_valid && st_ready` and it is legal.
- A request is **illegal** when any of these holds:
  - `st_op == 0`;
  - sh with `st_addr[0] == 1`;
  - sw with `st_addr[1:0] != 0`.
- Illegal requests are never enqueued. `st_err` is 1 in the cycle after such a request is presented with `st_ready == 1`. A request presented while `st_ready == 0` produces no error.
- Encoding of an accepted request, with `a = st_addr[1:0]`:
  - sb: byteen = `4'b0001 << a`; wdata = `{4{st_wdata[7:0]}}`.
  - sh: byteen = `a[1] ? 4'b1100 : 4'b0011`; wdata = `{2{st_wdata[15:0]}}`.
  - sw: byteen = `4'b1111`; wdata = `st_wdata`.
  - Stored address = `{st_addr[31:2], 2'b00}`.
- FIFO structure:
  - Circular buffer with read and write pointers of width $clog2(DEPTH); both wrap from DEPTH-1 to 0.
  - `count` tracks occupancy: +1 on accept only, -1 on drain only, unchanged on both or neither.
- `st_ready = (count != DEPTH)`. When full, a simultaneous drain does not open a slot in the same cycle.
- Drain handshake:
  - `mem_valid = !empty`; the `m_data_*` outputs show the head entry.
  - An entry drains when `mem_valid && mem_ready`.
  - While `mem_ready` is 0, the head entry and all `m_data_*` outputs hold stable.
- Entries drain strictly in program (acceptance) order.
- `ld_conflict` is combinational. It is 1 iff some occupied entry has address bits [31:2] equal to `ld_addr[31:2]`, independent of byte enables. An entry draining in the current cycle still counts. A request being accepted in the current cycle does not count.
- When empty, the `m_data_*` outputs are don't-care, but the RTL drives them from the head slot, never X-propagating logic.

## Timing
- Values while `reset == 0`:
  - pointers = 0, `count` = 0, `empty` = 1, `st_ready` = 1;
  - `mem_valid` = 0, `st_err` = 0, `ld_conflict` = 0;
  - `m_data_addr` = 0, `m_data_wdata` = 0, `m_data_byteen` = 0;
  - the storage array is cleared.
- Reset asserted mid-operation discards all pending entries immediately, without waiting for a clock edge. No write completes after reset is asserted.
- Enqueue-to-output latency is 1 cycle. A request accepted at edge N appears on `m_data_*` with `mem_valid = 1` after edge N when the FIFO was empty.
- Throughput: one accept and one drain per cycle sustained. With `mem_ready` held at 1 and one store per cycle, `count` stays at 1.
- `st_err` is registered and lasts exactly 1 cycle per rejected request. Back-to-back illegal requests give consecutive pulses.
- `st_ready`, `mem_valid`, `empty` and `count` change only on clock edges or on reset.

## Test plan
- Reset, then sb with addr 0x0000_3002 and wdata 0x1234_56AB -> next cycle: `m_data_addr` = 0x0000_3000, `m_data_wdata` = 0xABAB_ABAB, `m_data_byteen` = 4'b0100, `mem_valid` = 1, `count` = 1.
- sh at 0x10 and sw at 0x14 with `mem_ready` = 1, then sh at 0x11 -> entries appear in order with byteen 0011 then 1111. The sh at 0x11 is not enqueued, `st_err` pulses once the next cycle, and `count` stays 0.
- Hold `mem_ready` = 0 and issue 5 sw requests at 0x0, 0x4, 0x8, 0xC, 0x10 -> `st_ready` drops after the 4th, the 5th is held by the producer, and the head stays at 0x0. Then set `mem_ready` = 1 -> drains 0x0, 0x4, 0x8, 0xC, 0x10 in order, with the pointers wrapping.
- Full FIFO with `st_valid` and `mem_ready` both 1 -> only the drain happens that cycle and `count` goes 4 -> 3.
- Pending sb at 0x203, `ld_addr` = 0x200 -> `ld_conflict` = 1. With `ld_addr` = 0x204 -> `ld_conflict` = 0. After that entry drains -> `ld_conflict` = 0.
- With 3 entries pending, drive `reset` low between clock edges -> `mem_valid`, `count`, `m_data_*` and `ld_conflict` go to 0 and `st_ready` to 1 without a clock edge. After release, the first new store appears as the head entry.
